mmio_controller: RTL and testbench
==================================

# mmio_controller

Parametrised memory-mapped I/O and SRAM controller between the single-cycle CPU data port and the board peripherals. It decodes the CPU address into a top-of-space I/O window or external SRAM. The window holds N_OUT writable output registers, debounced button level/edge registers and synchronised switches. SRAM accesses run through a wait-state FSM that stalls the CPU until data is valid.

## Interface
- DATA_W, 16, CPU/SRAM data width
- ADDR_W, 18, address width
- N_OUT, 2, number of output registers (1..8)
- OUT_W, 10, width of each output register (≤ DATA_W)
- N_IN, 4, button count (≤ DATA_W)
- SW_W, 10, switch count (≤ DATA_W)
- BTN_ACTIVE_LOW, 1, raw buttons are inverted before use when 1
- DEB_CYCLES, 16, stable cycles required to accept a button change (≥ 2)
- MEM_WAIT, 1, SRAM access cycles (≥ 1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- addr  in  ADDR_W  CPU data address
- wr_en  in  1  CPU write request
- rd_en  in  1  CPU read request
- wdata  in  DATA_W  CPU write data
- rdata  out  DATA_W  CPU read data
- stall  out  1  CPU must hold request and not advance
- buttons  in  N_IN  raw asynchronous buttons
- switches  in  SW_W  raw asynchronous switches
- out_ports  out  N_OUT*OUT_W  output registers, register i at bits [i*OUT_W +: OUT_W]
- sram_addr  out  ADDR_W  SRAM address
- sram_ctrl  out  5  {we_n, ce_n, oe_n, lb_n, ub_n}, active-low
- sram_dq  inout  DATA_W  SRAM data bus

## Operation
- I/O window: addr[15:4] == 12'hFFF (addr[ADDR_W-1:16] ignored). Everything else is SRAM.
- Map (addr[3:0]):
  - 0x0..0x7: OUT i (i < N_OUT), R/W. Write stores wdata[OUT_W-1:0]. Read returns the value zero-extended.
  - 0x8: BTN_LEVEL, RO, debounced levels.
  - 0x9: BTN_EDGE, sticky press flags. Read returns the flags. Write-1-to-clear per bit.
  - 0xA: SWITCHES, RO, synchronised switches.
  - 0xB: STATUS, RO. bit0 = |BTN_EDGE, bit1 = FSM not IDLE.
  - Unmapped offsets and OUT i with i ≥ N_OUT: read 0, write ignored.
- wr_en and rd_en both high: treated as a write.
- I/O accesses are zero-wait. stall = 0. rdata is combinational from the selected register. Writes take effect at the clock edge.
- Input path:
  - buttons and switches pass through 2-flop synchronisers. buttons are inverted if BTN_ACTIVE_LOW.
  - Debounce, per button: counter clears while sync == level. It increments while they differ. At DEB_CYCLES-1 the level takes the sync value and the counter clears.
  - Net effect: a change is accepted after DEB_CYCLES consecutive differing cycles. A glitch shorter than that is discarded.
  - A 0→1 level transition sets the BTN_EDGE bit. A set and a W1C on the same bit in the same cycle: set wins.
- SRAM FSM, states IDLE, ACCESS, DONE:
  - IDLE: mem request (window miss and wr_en|rd_en) → ACCESS, wait counter = 0.
  - ACCESS: ce_n=0, lb_n=ub_n=0. Read: oe_n=0, we_n=1. Write: we_n=0, oe_n=1, sram_dq driven with wdata.
  - ACCESS counts MEM_WAIT cycles. On the last one a read captures sram_dq into the read latch. Then → DONE.
  - DONE: controls inactive, sram_dq Hi-Z. rdata = read latch. Then → IDLE unconditionally.
- stall = mem request AND state != DONE.
- sram_addr = addr, registered at the IDLE→ACCESS transition. The CPU holds addr, wdata, wr_en and rd_en stable while stall is high.
- sram_dq is Hi-Z in every state except ACCESS-write.

## Timing
- Reset values (reset low at an edge): out_ports 0, BTN_LEVEL 0, BTN_EDGE 0, debounce counters 0, synchronisers 0, FSM IDLE, sram_ctrl 5'b11111, sram_dq Hi-Z, read latch 0.
- stall is forced to 0 while reset is low.
- Reset mid-access: the FSM goes to IDLE at that edge and controls deassert the same cycle. The aborted write has undefined SRAM content.
- Memory request first seen in cycle T:
  - stall is high in T..T+MEM_WAIT (MEM_WAIT+1 cycles).
  - DONE occurs in cycle T+1+MEM_WAIT, where stall = 0 and the CPU completes.
  - A back-to-back memory request in T+2+MEM_WAIT starts from IDLE.
- A write to OUT i in cycle T is visible on out_ports and readable in T+1.
- Button visibility: a button change at input reaches the BTN_LEVEL register 2 (sync) + DEB_CYCLES cycles later. The edge flag sets in the same cycle as the level.
- Switch visibility: a switch change appears in SWITCHES after 2 cycles.

## Test plan
- Reset: drive reset=0 for 2 cycles with wr_en=1 → out_ports=0, sram_ctrl=5'b11111, stall=0, sram_dq=Z.
- Write 0x03FF to 0xFFF0 and 0x00A5 to 0xFFF1 → next cycle out_ports[9:0]=0x3FF, [19:10]=0x0A5. Reads return the same with stall=0. A write to 0xFFF5 is ignored and reads 0.
- Button debounce:
  - Press button 2 (raw low) for DEB_CYCLES-1 cycles → BTN_LEVEL stays 0.
  - Hold the press → BTN_LEVEL=0x4 and BTN_EDGE=0x4 at cycle 2+DEB_CYCLES, STATUS bit0=1.
  - Write 0x4 to 0xFFF9 → BTN_EDGE=0.
- Edge set vs clear: a new rising edge on button 0 in the same cycle as a W1C of 0x1 → BTN_EDGE bit0 remains 1.
- SRAM write 0xBEEF to addr 0x00123, MEM_WAIT=2:
  - stall high 3 cycles, we_n=0/ce_n=0 for 2 cycles, sram_dq=0xBEEF, sram_addr=0x00123.
  - SRAM read back returns 0xBEEF in the DONE cycle.
- Reset mid-access: reset low during ACCESS → next cycle IDLE, sram_ctrl=5'b11111, stall=0.

Source files
------------

// File: rtl/mmio_controller.sv
// mmio_controller: decodes the CPU data port into a top-of-space I/O window
// (output registers, debounced buttons, synchronised switches, status) or an
// external asynchronous SRAM reached through a stalling wait-state FSM.
module mmio_controller #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 18,
   parameter int N_OUT          = 2,
   parameter int OUT_W          = 10,
   parameter int N_IN           = 4,
   parameter int SW_W           = 10,
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int DEB_CYCLES     = 16,
   parameter int MEM_WAIT       = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [DATA_W-1:0]      wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic                   stall,
   input  logic [N_IN-1:0]        buttons,
   input  logic [SW_W-1:0]        switches,
   output logic [N_OUT*OUT_W-1:0] out_ports,
   output logic [ADDR_W-1:0]      sram_addr,
   output logic [4:0]             sram_ctrl,
   inout  wire  [DATA_W-1:0]      sram_dq
);

   localparam int CNT_W  = $clog2(DEB_CYCLES);
   localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   // {we_n, ce_n, oe_n, lb_n, ub_n}
   localparam logic [4:0] CTRL_IDLE  = 5'b11111;
   localparam logic [4:0] CTRL_READ  = 5'b10000;
   localparam logic [4:0] CTRL_WRITE = 5'b00100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic       io_hit;
   logic [3:0] io_off;
   logic       io_wr;
   logic       mem_req;

   assign io_hit  = (addr[15:4] == 12'hFFF);
   assign io_off  = addr[3:0];
   // A simultaneous read+write is a write, so wr_en alone qualifies writes.
   assign io_wr   = io_hit & wr_en;
   assign mem_req = ~io_hit & (wr_en | rd_en);

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [N_IN-1:0] btn_raw;
   logic [N_IN-1:0] btn_s1_q, btn_s1_d;
   logic [N_IN-1:0] btn_s2_q, btn_s2_d;
   logic [SW_W-1:0] sw_s1_q, sw_s1_d;
   logic [SW_W-1:0] sw_s2_q, sw_s2_d;

   assign btn_raw = (BTN_ACTIVE_LOW != 0) ? ~buttons : buttons;

   // Next values of the two-stage synchroniser chains
   always_comb begin
      btn_s1_d = btn_raw;
      btn_s2_d = btn_s1_q;
      sw_s1_d  = switches;
      sw_s2_d  = sw_s1_q;
   end

   // Synchroniser flops
   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-button debounce: a level change is accepted only after the
   // synchronised input has disagreed for DEB_CYCLES consecutive cycles.
   // ------------------------------------------------------------------
   logic [N_IN-1:0] btn_lvl;
   logic [N_IN-1:0] btn_lvl_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_deb
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             lvl_q, lvl_d;

         // Count disagreeing cycles, accept the new level on the last one
         always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (btn_s2_q[gi] == lvl_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
               lvl_d = btn_s2_q[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Debounce counter and accepted level
         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt_q <= '0;
               lvl_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               lvl_q <= lvl_d;
            end
         end

         assign btn_lvl[gi]     = lvl_q;
         assign btn_lvl_nxt[gi] = lvl_d;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Sticky press flags with write-1-to-clear; a new press wins over a
   // clear in the same cycle so no press is ever lost.
   // ------------------------------------------------------------------
   logic [N_IN-1:0] btn_edge_q, btn_edge_d;

   // Clear first, then OR in rising edges of the debounced level
   always_comb begin
      btn_edge_d = btn_edge_q;
      if (io_wr && (io_off == 4'h9)) begin
         btn_edge_d = btn_edge_d & ~wdata[N_IN-1:0];
      end
      btn_edge_d = btn_edge_d | (btn_lvl_nxt & ~btn_lvl);
   end

   // Press flag register
   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_edge_q <= '0;
      end else begin
         btn_edge_q <= btn_edge_d;
      end
   end

   // ------------------------------------------------------------------
   // Output registers, one per window slot 0..N_OUT-1
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_out
         logic [OUT_W-1:0] val_q, val_d;

         // Load the low OUT_W bits of the write data when addressed
         always_comb begin
            val_d = val_q;
            if (io_wr && (io_off == 4'(gi))) begin
               val_d = wdata[OUT_W-1:0];
            end
         end

         // Output register storage
         always_ff @(posedge clk) begin
            if (!reset) begin
               val_q <= '0;
            end else begin
               val_q <= val_d;
            end
         end

         assign out_ports[gi*OUT_W +: OUT_W] = val_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // SRAM wait-state FSM
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [4:0]          ctrl_q, ctrl_d;
   logic                dq_oe_q, dq_oe_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]   rd_latch_q, rd_latch_d;

   // Next-state logic; the SRAM controls are computed one cycle ahead so
   // they come straight from flops while in ACCESS.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      ctrl_d      = ctrl_q;
      dq_oe_d     = dq_oe_q;
      sram_addr_d = sram_addr_q;
      rd_latch_d  = rd_latch_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               state_d     = ST_ACCESS;
               wait_d      = '0;
               sram_addr_d = addr;
               if (wr_en) begin
                  ctrl_d  = CTRL_WRITE;
                  dq_oe_d = 1'b1;
               end else begin
                  ctrl_d  = CTRL_READ;
                  dq_oe_d = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            if (wait_q == WAIT_W'(MEM_WAIT - 1)) begin
               // dq_oe_q doubles as the write flag of the current access
               if (!dq_oe_q) begin
                  rd_latch_d = sram_dq;
               end
               state_d = ST_DONE;
               ctrl_d  = CTRL_IDLE;
               dq_oe_d = 1'b0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            ctrl_d  = CTRL_IDLE;
            dq_oe_d = 1'b0;
         end
      endcase
   end

   // FSM state and registered SRAM interface
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         ctrl_q      <= CTRL_IDLE;
         dq_oe_q     <= 1'b0;
         sram_addr_q <= '0;
         rd_latch_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         ctrl_q      <= ctrl_d;
         dq_oe_q     <= dq_oe_d;
         sram_addr_q <= sram_addr_d;
         rd_latch_q  <= rd_latch_d;
      end
   end

   assign sram_ctrl = ctrl_q;
   assign sram_addr = sram_addr_q;
   // The CPU holds wdata stable while stalled, so it can drive the bus directly.
   assign sram_dq   = dq_oe_q ? wdata : 'z;
   assign stall     = reset & mem_req & (state_q != ST_DONE);

   // ------------------------------------------------------------------
   // Read data: I/O registers are zero-wait, memory returns the latch
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] io_rdata;

   // Select the addressed window register, zero-extended
   always_comb begin
      io_rdata = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (io_off == 4'(i)) begin
            io_rdata[OUT_W-1:0] = out_ports[i*OUT_W +: OUT_W];
         end
      end
      case (io_off)
         4'h8:    io_rdata[N_IN-1:0] = btn_lvl;
         4'h9:    io_rdata[N_IN-1:0] = btn_edge_q;
         4'hA:    io_rdata[SW_W-1:0] = sw_s2_q;
         4'hB:    io_rdata[1:0]      = {(state_q != ST_IDLE), |btn_edge_q};
         default: ;
      endcase
   end

   assign rdata = io_hit ? io_rdata : rd_latch_q;

endmodule

// File: tb/tb_mmio_controller.sv
// Directed bench for mmio_controller: table of I/O window vectors plus
// hand-written sequences for debounce, press-flag races and SRAM accesses.
module tb_mmio_controller;

   localparam int MW  = 2;
   localparam int DEB = 16;

   logic        clk;
   logic        reset;
   logic [17:0] addr;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        stall;
   logic [3:0]  buttons;
   logic [9:0]  switches;
   logic [19:0] out_ports;
   logic [17:0] sram_addr;
   logic [4:0]  sram_ctrl;
   wire  [15:0] sram_dq;

   int n_cmp = 0;
   int n_bad = 0;

   mmio_controller #(.MEM_WAIT(MW), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .buttons   (buttons),
      .switches  (switches),
      .out_ports (out_ports),
      .sram_addr (sram_addr),
      .sram_ctrl (sram_ctrl),
      .sram_dq   (sram_dq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model plus a bus keeper that drives 0x1234 whenever the chip is
   // deselected; any DUT drive then corrupts the keeper value.
   logic [15:0] sram_mem [0:255];
   logic        model_oe;
   logic        keeper_en;
   assign model_oe  = !sram_ctrl[3] && !sram_ctrl[2] && sram_ctrl[4];
   assign keeper_en = sram_ctrl[3];
   assign sram_dq = model_oe  ? sram_mem[sram_addr[7:0]] : 16'hzzzz;
   assign sram_dq = keeper_en ? 16'h1234 : 16'hzzzz;

   always @(posedge clk) begin
      if (!reset)
         sram_mem[8'h24] <= 16'h5A5A;
      else if (!sram_ctrl[3] && !sram_ctrl[4])
         sram_mem[sram_addr[7:0]] <= sram_dq;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic io_read(input string nm, input logic [17:0] a, input logic [15:0] want);
      wr_en = 1'b0; rd_en = 1'b1; addr = a;
      #1;
      chk(nm, 32'(rdata), 32'(want));
      chk({nm, "_stall"}, 32'(stall), 32'h0);
      $display("io read  %s addr=%05h rdata=%04h", nm, a, rdata);
      rd_en = 1'b0;
   endtask

   task automatic io_write(input logic [17:0] a, input logic [15:0] d);
      wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d;
      step();
      $display("io write addr=%05h wdata=%04h", a, d);
      wr_en = 1'b0;
   endtask

   // One SRAM access from request to completion, checking every cycle
   task automatic sram_op(input logic is_wr, input logic [17:0] a,
                          input logic [15:0] wd, input logic [15:0] want_rd);
      logic [4:0] acc_ctrl;
      acc_ctrl = is_wr ? 5'b00100 : 5'b10000;
      wr_en = is_wr; rd_en = !is_wr; addr = a; wdata = wd;
      #1;
      chk("sram_stall_req", 32'(stall), 32'h1);
      chk("sram_ctrl_req", 32'(sram_ctrl), 32'h1F);
      for (int c = 1; c <= MW; c++) begin
         step();
         chk("sram_stall_acc", 32'(stall), 32'h1);
         chk("sram_ctrl_acc", 32'(sram_ctrl), 32'(acc_ctrl));
         chk("sram_addr_acc", 32'(sram_addr), 32'(a));
         if (is_wr) chk("sram_dq_wr", 32'(sram_dq), 32'(wd));
      end
      step();
      chk("sram_stall_done", 32'(stall), 32'h0);
      chk("sram_ctrl_done", 32'(sram_ctrl), 32'h1F);
      chk("sram_dq_hiz_done", 32'(sram_dq), 32'h1234);
      if (!is_wr) chk("sram_rdata", 32'(rdata), 32'(want_rd));
      $display("sram %s addr=%05h wdata=%04h rdata=%04h", is_wr ? "wr" : "rd", a, wd, rdata);
      wr_en = 1'b0; rd_en = 1'b0;
      step();
   endtask

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [17:0] a;
      logic [15:0] wd;
      logic        chk_rd;
      logic [15:0] exp_rd;
      logic [19:0] exp_out;
   } vec_t;

   vec_t vecs [16];

   initial begin
      //         wr    rd    addr        wdata     chk   exp_rd    exp_out
      vecs[0]  = '{1'b1, 1'b0, 18'h0FFF0, 16'h03FF, 1'b0, 16'h0000, 20'h003FF};
      vecs[1]  = '{1'b1, 1'b0, 18'h0FFF1, 16'h00A5, 1'b0, 16'h0000, 20'h297FF};
      vecs[2]  = '{1'b0, 1'b1, 18'h0FFF0, 16'h0000, 1'b1, 16'h03FF, 20'h297FF};
      vecs[3]  = '{1'b0, 1'b1, 18'h0FFF1, 16'h0000, 1'b1, 16'h00A5, 20'h297FF};
      vecs[4]  = '{1'b1, 1'b0, 18'h0FFF5, 16'h1234, 1'b0, 16'h0000, 20'h297FF};
      vecs[5]  = '{1'b0, 1'b1, 18'h0FFF5, 16'h0000, 1'b1, 16'h0000, 20'h297FF};
      vecs[6]  = '{1'b1, 1'b0, 18'h0FFF0, 16'hFC12, 1'b0, 16'h0000, 20'h29412};
      vecs[7]  = '{1'b0, 1'b1, 18'h0FFF0, 16'h0000, 1'b1, 16'h0012, 20'h29412};
      vecs[8]  = '{1'b1, 1'b1, 18'h0FFF1, 16'h0155, 1'b0, 16'h0000, 20'h55412};
      vecs[9]  = '{1'b0, 1'b1, 18'h0FFF1, 16'h0000, 1'b1, 16'h0155, 20'h55412};
      vecs[10] = '{1'b0, 1'b1, 18'h3FFF1, 16'h0000, 1'b1, 16'h0155, 20'h55412};
      vecs[11] = '{1'b0, 1'b1, 18'h0FFFA, 16'h0000, 1'b1, 16'h02A5, 20'h55412};
      vecs[12] = '{1'b0, 1'b1, 18'h0FFFB, 16'h0000, 1'b1, 16'h0000, 20'h55412};
      vecs[13] = '{1'b0, 1'b1, 18'h0FFF8, 16'h0000, 1'b1, 16'h0000, 20'h55412};
      vecs[14] = '{1'b1, 1'b0, 18'h0FFF7, 16'hAAAA, 1'b0, 16'h0000, 20'h55412};
      vecs[15] = '{1'b0, 1'b1, 18'h0FFF7, 16'h0000, 1'b1, 16'h0000, 20'h55412};

      // ---------------- reset with a write pending ----------------
      reset = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
      addr = 18'h0FFF0; wdata = 16'hFFFF;
      buttons = 4'hF; switches = 10'h2A5;
      step();
      chk("rst_out_ports", 32'(out_ports), 32'h0);
      addr = 18'h00010;
      #1;
      chk("rst_stall", 32'(stall), 32'h0);
      step();
      chk("rst_sram_ctrl", 32'(sram_ctrl), 32'h1F);
      chk("rst_sram_dq_hiz", 32'(sram_dq), 32'h1234);
      chk("rst_out_ports2", 32'(out_ports), 32'h0);
      reset = 1'b1; wr_en = 1'b0; addr = 18'h0;
      step();
      step();

      // ---------------- I/O window vector table ----------------
      for (int v = 0; v < 16; v++) begin
         wr_en = vecs[v].wr; rd_en = vecs[v].rd;
         addr = vecs[v].a; wdata = vecs[v].wd;
         #1;
         if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rd));
         chk($sformatf("vec%0d_stall", v), 32'(stall), 32'h0);
         step();
         chk($sformatf("vec%0d_out_ports", v), 32'(out_ports), 32'(vecs[v].exp_out));
         $display("vec %0d wr=%0b rd=%0b addr=%05h wdata=%04h rdata=%04h out=%05h",
                  v, vecs[v].wr, vecs[v].rd, vecs[v].a, vecs[v].wd, rdata, out_ports);
      end
      wr_en = 1'b0; rd_en = 1'b0;

      // ---------------- glitch of DEB-1 cycles is discarded ----------------
      buttons = 4'hB;
      for (int i = 0; i < DEB - 1; i++) step();
      buttons = 4'hF;
      for (int i = 0; i < 30; i++) step();
      io_read("glitch_level", 18'h0FFF8, 16'h0000);
      io_read("glitch_edge", 18'h0FFF9, 16'h0000);

      // ---------------- held press: accepted after 2+DEB edges ----------------
      buttons = 4'hB;
      for (int i = 0; i < DEB + 1; i++) step();
      io_read("press_level_early", 18'h0FFF8, 16'h0000);
      step();
      io_read("press_level", 18'h0FFF8, 16'h0004);
      io_read("press_edge", 18'h0FFF9, 16'h0004);
      io_read("press_status", 18'h0FFFB, 16'h0001);
      io_write(18'h0FFF9, 16'h0004);
      io_read("w1c_edge", 18'h0FFF9, 16'h0000);
      io_read("w1c_level", 18'h0FFF8, 16'h0004);

      // ---------------- new press on btn0 races a W1C of bit0 ----------------
      buttons = 4'hA;
      for (int i = 0; i < DEB + 1; i++) step();
      io_write(18'h0FFF9, 16'h0001);
      io_read("race_edge", 18'h0FFF9, 16'h0001);
      io_read("race_level", 18'h0FFF8, 16'h0005);
      io_write(18'h0FFF9, 16'h0001);
      io_read("race_clear_edge", 18'h0FFF9, 16'h0000);
      io_read("race_status", 18'h0FFFB, 16'h0000);

      // ---------------- SRAM write / read-back / back-to-back ----------------
      sram_op(1'b1, 18'h00123, 16'hBEEF, 16'h0000);
      sram_op(1'b0, 18'h00123, 16'h0000, 16'hBEEF);
      sram_op(1'b0, 18'h00124, 16'h0000, 16'h5A5A);
      sram_op(1'b0, 18'h00123, 16'h0000, 16'hBEEF);

      // ---------------- reset during ACCESS ----------------
      wr_en = 1'b1; rd_en = 1'b0; addr = 18'h00050; wdata = 16'h0F0F;
      step();
      chk("abort_ctrl_acc", 32'(sram_ctrl), 32'h04);
      reset = 1'b0;
      #1;
      chk("abort_stall_in_reset", 32'(stall), 32'h0);
      step();
      chk("abort_ctrl_idle", 32'(sram_ctrl), 32'h1F);
      chk("abort_stall", 32'(stall), 32'h0);
      chk("abort_dq_hiz", 32'(sram_dq), 32'h1234);
      chk("abort_out_ports", 32'(out_ports), 32'h0);
      $display("abort reset during access ctrl=%02h stall=%0b", sram_ctrl, stall);
      wr_en = 1'b0;
      reset = 1'b1;
      step();
      io_read("abort_status", 18'h0FFFB, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
